// File: rtl/i2s_stereo_packer_if.sv
// Stereo packer bus: decoder word strobes in, stereo frame stream and status out.
// Latency: n/a (signal bundle only).
// Backpressure: the frame side uses valid/ready; the decoder side cannot be stalled.
interface i2s_stereo_packer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) ();
    logic [DATA_WIDTH-1:0]              left_word_i;
    logic                               left_word_valid_i;
    logic [DATA_WIDTH-1:0]              right_word_i;
    logic                               right_word_valid_i;
    logic [2*DATA_WIDTH-1:0]            frame_o;
    logic                               frame_valid_o;
    logic                               frame_ready_i;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o;
    logic                               overflow_o;
    logic                               sync_err_o;
    logic                               clear_i;

    // Driver side: decoder words in, consumer ready and flag clear.
    modport master (
        output left_word_i, left_word_valid_i, right_word_i, right_word_valid_i,
        output frame_ready_i, clear_i,
        input  frame_o, frame_valid_o, fifo_level_o, overflow_o, sync_err_o
    );

    // Packer side.
    modport slave (
        input  left_word_i, left_word_valid_i, right_word_i, right_word_valid_i,
        input  frame_ready_i, clear_i,
        output frame_o, frame_valid_o, fifo_level_o, overflow_o, sync_err_o
    );
endinterface

// File: rtl/i2s_stereo_packer.sv
// Pairs decoder left/right strobes into {left,right} frames and buffers them in a FIFO.
// Latency: frame visible one cycle after the right strobe when the FIFO was empty.
// Backpressure: frame_ready_i stalls the FIFO; frames arriving while full are dropped (overflow).
module i2s_stereo_packer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    i2s_stereo_packer_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = 2 * DATA_WIDTH;

    typedef enum logic {
        WAIT_LEFT  = 1'b0,
        WAIT_RIGHT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DATA_WIDTH-1:0]  hold;
    logic [DATA_WIDTH-1:0]  hold_next;
    logic                   push_req;
    logic [FW-1:0]          push_dat;
    logic                   sync_evt;

    logic [FW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic                   pop;
    logic                   push_ok;
    logic                   overflow_evt;
    logic                   overflow;
    logic                   sync_err;

    // Pairing state and held left word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LEFT;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // Pairing decisions: which word to keep, when to push, when order is violated.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        push_req   = 1'b0;
        push_dat   = {hold, bus.right_word_i};
        sync_evt   = 1'b0;
        if (bus.left_word_valid_i && bus.right_word_valid_i) begin
            // Simultaneous strobes cannot be ordered; drop both and resync.
            sync_evt   = 1'b1;
            state_next = WAIT_LEFT;
        end else if (bus.left_word_valid_i) begin
            // A second left before its right is an error, but the newest left wins.
            if (state == WAIT_RIGHT) begin
                sync_evt = 1'b1;
            end
            hold_next  = bus.left_word_i;
            state_next = WAIT_RIGHT;
        end else if (bus.right_word_valid_i) begin
            if (state == WAIT_RIGHT) begin
                push_req   = 1'b1;
                state_next = WAIT_LEFT;
            end else begin
                sync_evt = 1'b1;
            end
        end
    end

    assign pop          = bus.frame_valid_o && bus.frame_ready_i;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign push_ok      = push_req && ((level < LW'(FIFO_DEPTH)) || pop);
    assign overflow_evt = push_req && !push_ok;

    // Frame storage; contents need no reset since the output is gated by level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (bus.clear_i) begin
                overflow <= 1'b0;
            end
            if (sync_evt) begin
                sync_err <= 1'b1;
            end else if (bus.clear_i) begin
                sync_err <= 1'b0;
            end
        end
    end

    assign bus.frame_valid_o = (level != '0);
    assign bus.frame_o       = bus.frame_valid_o ? mem[rd_ptr] : '0;
    assign bus.fifo_level_o  = level;
    assign bus.overflow_o    = overflow;
    assign bus.sync_err_o    = sync_err;
endmodule

// File: tb/tb_i2s_stereo_packer.sv
// Directed + random checks of the stereo packer against a queue-based reference model.
// Latency: model advances once per clock edge and is compared 1 time unit after it.
// Backpressure: ready patterns, stalls and full-FIFO overflow are all exercised.
module tb_i2s_stereo_packer;
    localparam int DW    = 24;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2s_stereo_packer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    i2s_stereo_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: an ideal bounded queue of frames plus an optional unpaired left word.
    logic [2*DW-1:0] mq[$];
    bit              pend;
    logic [DW-1:0]   pend_w;
    bit              m_ovf;
    bit              m_serr;
    logic [2*DW-1:0] last_pop;
    int              rx;
    int              max_level;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [2*DW-1:0] ef;
        ef = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".valid"}, 64'(bus.frame_valid_o), 64'(mq.size() != 0));
        chk({tag, ".frame"}, 64'(bus.frame_o), 64'(ef));
        chk({tag, ".level"}, 64'(bus.fifo_level_o), 64'(mq.size()));
        chk({tag, ".ovf"}, 64'(bus.overflow_o), 64'(m_ovf));
        chk({tag, ".serr"}, 64'(bus.sync_err_o), 64'(m_serr));
        if (int'(bus.fifo_level_o) > max_level) max_level = int'(bus.fifo_level_o);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare everything.
    task automatic cyc(input string tag, input bit lv, input logic [DW-1:0] lw,
                       input bit rv, input logic [DW-1:0] rw, input bit rdy, input bit clr);
        bit pop;
        bit ovf_ev;
        bit serr_ev;
        bit have;
        logic [2*DW-1:0] f;
        bus.left_word_valid_i  = lv;
        bus.left_word_i        = lw;
        bus.right_word_valid_i = rv;
        bus.right_word_i       = rw;
        bus.frame_ready_i      = rdy;
        bus.clear_i            = clr;
        pop     = (mq.size() != 0) && rdy;
        ovf_ev  = 1'b0;
        serr_ev = 1'b0;
        have    = 1'b0;
        f       = '0;
        @(posedge clk);
        #1;
        if (pop) begin
            last_pop = mq.pop_front();
            rx++;
        end
        if (lv && rv) begin
            serr_ev = 1'b1;
            pend    = 1'b0;
        end else if (lv) begin
            if (pend) serr_ev = 1'b1;
            pend   = 1'b1;
            pend_w = lw;
        end else if (rv) begin
            if (pend) begin
                have = 1'b1;
                f    = {pend_w, rw};
            end else begin
                serr_ev = 1'b1;
            end
            pend = 1'b0;
        end
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(f);
            else ovf_ev = 1'b1;
        end
        if (ovf_ev) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (serr_ev) m_serr = 1'b1; else if (clr) m_serr = 1'b0;
        bus.left_word_valid_i  = 1'b0;
        bus.right_word_valid_i = 1'b0;
        bus.clear_i            = 1'b0;
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input bit rdy);
        cyc(tag, 1'b0, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.left_word_valid_i  = 1'b0;
        bus.right_word_valid_i = 1'b0;
        bus.frame_ready_i      = 1'b0;
        bus.clear_i            = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        pend   = 1'b0;
        pend_w = '0;
        m_ovf  = 1'b0;
        m_serr = 1'b0;
        chk("reset.frame", 64'(bus.frame_o), 64'd0);
        chk("reset.valid", 64'(bus.frame_valid_o), 64'd0);
        chk("reset.level", 64'(bus.fifo_level_o), 64'd0);
        chk("reset.ovf", 64'(bus.overflow_o), 64'd0);
        chk("reset.serr", 64'(bus.sync_err_o), 64'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) idle(tag, 1'b1);
        chk({tag, ".empty"}, 64'(bus.frame_valid_o), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] lw;
        logic [DW-1:0] rw;
        bit            rpat [4];
        int            k;
        bus.left_word_i        = '0;
        bus.right_word_i       = '0;
        bus.left_word_valid_i  = 1'b0;
        bus.right_word_valid_i = 1'b0;
        bus.frame_ready_i      = 1'b0;
        bus.clear_i            = 1'b0;
        rx = 0;
        max_level = 0;
        last_pop = '0;

        // 1: basic pairing with a gap between left and right
        do_reset();
        cyc("t1.left", 1'b1, 24'h123456, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("t1.gap", 1'b0);
        cyc("t1.right", 1'b0, '0, 1'b1, 24'hABCDEF, 1'b0, 1'b0);
        chk("t1.frame_const", 64'(bus.frame_o), 64'h123456ABCDEF);
        chk("t1.level_const", 64'(bus.fifo_level_o), 64'd1);
        idle("t1.pop", 1'b1);
        chk("t1.valid_after_pop", 64'(bus.frame_valid_o), 64'd0);
        chk("t1.level_after_pop", 64'(bus.fifo_level_o), 64'd0);

        // 2: channel-order error
        do_reset();
        cyc("t2.r", 1'b0, '0, 1'b1, 24'h000001, 1'b0, 1'b0);
        cyc("t2.l1", 1'b1, 24'h111111, 1'b0, '0, 1'b0, 1'b0);
        cyc("t2.l2", 1'b1, 24'h222222, 1'b0, '0, 1'b0, 1'b0);
        cyc("t2.r2", 1'b0, '0, 1'b1, 24'h333333, 1'b0, 1'b0);
        chk("t2.serr_const", 64'(bus.sync_err_o), 64'd1);
        chk("t2.level_const", 64'(bus.fifo_level_o), 64'd1);
        chk("t2.frame_const", 64'(bus.frame_o), 64'h222222333333);
        drain("t2.drain");
        cyc("t2.clear", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("t2.serr_cleared", 64'(bus.sync_err_o), 64'd0);

        // 3: overflow with ready held low
        do_reset();
        for (int j = 0; j < 9; j++) begin
            cyc("t3.l", 1'b1, DW'(j), 1'b0, '0, 1'b0, 1'b0);
            cyc("t3.r", 1'b0, '0, 1'b1, DW'(32'h800000 + j), 1'b0, 1'b0);
        end
        chk("t3.level_const", 64'(bus.fifo_level_o), 64'd8);
        chk("t3.ovf_const", 64'(bus.overflow_o), 64'd1);
        for (int j = 0; j < 8; j++) begin
            chk("t3.drain_frame", 64'(bus.frame_o), {16'd0, DW'(j), DW'(32'h800000 + j)});
            idle("t3.drain", 1'b1);
        end
        chk("t3.empty", 64'(bus.frame_valid_o), 64'd0);

        // 4: full FIFO with a simultaneous pop on the 9th push
        do_reset();
        for (int j = 0; j < 8; j++) begin
            cyc("t4.l", 1'b1, DW'(j), 1'b0, '0, 1'b0, 1'b0);
            cyc("t4.r", 1'b0, '0, 1'b1, DW'(32'h800000 + j), 1'b0, 1'b0);
        end
        cyc("t4.l9", 1'b1, 24'd8, 1'b0, '0, 1'b0, 1'b0);
        cyc("t4.r9", 1'b0, '0, 1'b1, 24'h800008, 1'b1, 1'b0);
        chk("t4.ovf_const", 64'(bus.overflow_o), 64'd0);
        chk("t4.level_const", 64'(bus.fifo_level_o), 64'd8);
        drain("t4.drain");
        chk("t4.last_frame", 64'(last_pop), 64'h000008800008);

        // 5: wrap-around with ready pattern 1,0,0,1
        do_reset();
        rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;
        rx = 0;
        max_level = 0;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            lw = DW'($urandom);
            rw = DW'($urandom);
            cyc("t5.l", 1'b1, lw, 1'b0, '0, rpat[k % 4], 1'b0);
            k++;
            cyc("t5.r", 1'b0, '0, 1'b1, rw, rpat[k % 4], 1'b0);
            k++;
        end
        for (int i = 0; i < 40 && mq.size() != 0; i++) begin
            idle("t5.drain", rpat[k % 4]);
            k++;
        end
        chk("t5.rx_count", 64'(rx), 64'd20);
        chk("t5.no_ovf", 64'(bus.overflow_o), 64'd0);
        chk("t5.max_level_ok", 64'(max_level <= DEPTH), 64'd1);

        // 6: reset mid-operation
        do_reset();
        for (int j = 0; j < 3; j++) begin
            cyc("t6.l", 1'b1, DW'($urandom), 1'b0, '0, 1'b0, 1'b0);
            cyc("t6.r", 1'b0, '0, 1'b1, DW'($urandom), 1'b0, 1'b0);
        end
        cyc("t6.pend", 1'b1, 24'h5A5A5A, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        cyc("t6.r_only", 1'b0, '0, 1'b1, 24'h777777, 1'b0, 1'b0);
        chk("t6.serr_const", 64'(bus.sync_err_o), 64'd1);
        chk("t6.no_frame", 64'(bus.frame_valid_o), 64'd0);

        // Random soak: arbitrary strobes, ready and clear
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(0, 99) < 45), DW'($urandom),
                ($urandom_range(0, 99) < 45), DW'($urandom),
                ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
